ntr_cmd_sched: RTL and testbench

Command scheduler between the NTR command decoder, the NTR word responder and the UART receive FIFO. Once a 64-bit command is complete, it decodes the opcode. It then sequences FIFO reads, packing bytes into 32-bit response words, and presents one word per responder request through a two-entry (output + staging) buffer. It replaces the ad-hoc top-level dispatch logic and adds bulk FIFO streaming plus error status.

---
 rtl/ntr_cmd_sched_if.sv | 30 +++
 rtl/ntr_cmd_sched.sv | 250 +++++++++++++++++++++++++
 tb/tb_ntr_cmd_sched.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ntr_cmd_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : ntr_cmd_sched_if
// Brief    : Command/FIFO/responder signal bundle for the NTR command scheduler
// Revision : 1.0 - initial release
// ============================================================================
interface ntr_cmd_sched_if;
    logic [63:0] command;
    logic        cmd_ready;
    logic        word_req;
    logic [7:0]  fifo_data;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [31:0] data_word;
    logic        word_valid;
    logic        led;
    logic        busy;
    logic [1:0]  status;

    modport master (
        output command, cmd_ready, word_req, fifo_data, fifo_empty,
        input  fifo_rd_en, data_word, word_valid, led, busy, status
    );

    modport slave (
        input  command, cmd_ready, word_req, fifo_data, fifo_empty,
        output fifo_rd_en, data_word, word_valid, led, busy, status
    );
endinterface
`default_nettype wire

// File: rtl/ntr_cmd_sched.sv
`default_nettype none
// ============================================================================
// Module   : ntr_cmd_sched
// Brief    : Decodes NTR commands and streams UART FIFO bytes as 32-bit words
// Revision : 1.0 - initial release
// ============================================================================
module ntr_cmd_sched #(
    parameter int          MAX_WORDS = 128,
    parameter logic [31:0] CHIP_ID   = 32'h807F01E0
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    ntr_cmd_sched_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DECODE  = 3'd1,
        S_FILL    = 3'd2,
        S_PRESENT = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [7:0] c_MAX_WORDS = 8'(MAX_WORDS);

    state_t      state_q, state_d;
    logic [31:0] data_q, data_d;
    logic [31:0] stage_q, stage_d;
    logic [23:0] acc_q, acc_d;
    logic        valid_q, valid_d;
    logic        stage_full_q, stage_full_d;
    logic        led_q, led_d;
    logic        phase_q, phase_d;
    logic        popped_q, popped_d;
    logic        empty_a_q, empty_a_d;
    logic        byte_mode_q, byte_mode_d;
    logic [1:0]  status_q, status_d;
    logic [1:0]  slot_q, slot_d;
    logic [7:0]  nwords_q, nwords_d;
    logic [7:0]  filled_q, filled_d;

    logic        w_pop;
    logic        w_done_word;
    logic [7:0]  w_byte;
    logic [31:0] w_word;
    logic [7:0]  w_cnt;
    logic        w_unused;

    assign w_unused = ^{bus.command[63:57], bus.command[55:16]};

    // Pop only in slot phase A, never while staging is full or the command is being withdrawn
    assign w_pop = (state_q == S_FILL) && !phase_q && !stage_full_q &&
                   bus.cmd_ready && !bus.fifo_empty;

    assign bus.fifo_rd_en = w_pop;
    assign bus.data_word  = data_q;
    assign bus.word_valid = valid_q;
    assign bus.led        = led_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.status     = status_q;

    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        stage_d      = stage_q;
        acc_d        = acc_q;
        valid_d      = valid_q;
        stage_full_d = stage_full_q;
        led_d        = led_q;
        phase_d      = phase_q;
        popped_d     = popped_q;
        empty_a_d    = empty_a_q;
        byte_mode_d  = byte_mode_q;
        status_d     = status_q;
        slot_d       = slot_q;
        nwords_d     = nwords_q;
        filled_d     = filled_q;
        w_done_word  = 1'b0;
        w_word       = 32'h0;
        w_byte       = popped_q ? bus.fifo_data : 8'h00;

        w_cnt = bus.command[15:8];
        if (w_cnt == 8'd0) begin
            w_cnt = 8'd1;
        end else if (w_cnt > c_MAX_WORDS) begin
            w_cnt = c_MAX_WORDS;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_ready) begin
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                if (!bus.cmd_ready) begin
                    state_d = S_IDLE;
                end else begin
                    valid_d = 1'b1;
                    state_d = S_PRESENT;
                    case (bus.command[7:0])
                        8'hFF: begin
                            led_d  = bus.command[56];
                            data_d = 32'd1;
                        end
                        8'h90: data_d = CHIP_ID;
                        8'h9F: data_d = 32'hFFFF_FFFF;
                        8'h24: begin
                            data_d   = {22'b0, status_q, 7'b0, bus.fifo_empty};
                            status_d = 2'b00;
                        end
                        8'h22, 8'h23: begin
                            valid_d      = 1'b0;
                            state_d      = S_FILL;
                            byte_mode_d  = (bus.command[7:0] == 8'h22);
                            nwords_d     = (bus.command[7:0] == 8'h22) ? 8'd1 : w_cnt;
                            filled_d     = 8'd0;
                            slot_d       = 2'd0;
                            phase_d      = 1'b0;
                            popped_d     = 1'b0;
                            stage_full_d = 1'b0;
                        end
                        default: data_d = 32'h0;
                    endcase
                    if (bus.word_req) begin
                        status_d[1] = 1'b1;
                    end
                end
            end

            S_FILL, S_PRESENT: begin
                if (!bus.cmd_ready) begin
                    state_d      = S_IDLE;
                    valid_d      = 1'b0;
                    stage_full_d = 1'b0;
                end else begin
                    // Consumption is resolved before any newly filled word is placed
                    if (bus.word_req) begin
                        if (valid_q) begin
                            if (stage_full_q) begin
                                data_d       = stage_q;
                                stage_full_d = 1'b0;
                            end else begin
                                valid_d = 1'b0;
                                if (state_q == S_PRESENT) begin
                                    state_d = S_DONE;
                                end
                            end
                        end else begin
                            status_d[1] = 1'b1;
                        end
                    end

                    if (state_q == S_FILL) begin
                        if (!phase_q) begin
                            if (!stage_full_q) begin
                                phase_d   = 1'b1;
                                popped_d  = w_pop;
                                empty_a_d = bus.fifo_empty;
                            end
                        end else begin
                            phase_d = 1'b0;
                            if (!popped_q) begin
                                status_d[0] = 1'b1;
                            end
                            if (byte_mode_q) begin
                                w_done_word = 1'b1;
                                w_word      = {7'b0, empty_a_q, 16'b0, w_byte};
                            end else begin
                                slot_d = slot_q + 2'd1;
                                case (slot_q)
                                    2'd0: acc_d[7:0]   = w_byte;
                                    2'd1: acc_d[15:8]  = w_byte;
                                    2'd2: acc_d[23:16] = w_byte;
                                    default: begin
                                        w_done_word = 1'b1;
                                        w_word      = {w_byte, acc_q};
                                    end
                                endcase
                            end
                            if (w_done_word) begin
                                filled_d = filled_q + 8'd1;
                                if (!valid_d) begin
                                    data_d  = w_word;
                                    valid_d = 1'b1;
                                end else begin
                                    stage_d      = w_word;
                                    stage_full_d = 1'b1;
                                end
                                if (filled_d == nwords_q) begin
                                    state_d = S_PRESENT;
                                end
                            end
                        end
                    end
                end
            end

            S_DONE: begin
                if (bus.word_req) begin
                    data_d = 32'h0;
                end
                if (!bus.cmd_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            data_q       <= 32'h0;
            stage_q      <= 32'h0;
            acc_q        <= 24'h0;
            valid_q      <= 1'b0;
            stage_full_q <= 1'b0;
            led_q        <= 1'b0;
            phase_q      <= 1'b0;
            popped_q     <= 1'b0;
            empty_a_q    <= 1'b0;
            byte_mode_q  <= 1'b0;
            status_q     <= 2'b00;
            slot_q       <= 2'd0;
            nwords_q     <= 8'd0;
            filled_q     <= 8'd0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            stage_q      <= stage_d;
            acc_q        <= acc_d;
            valid_q      <= valid_d;
            stage_full_q <= stage_full_d;
            led_q        <= led_d;
            phase_q      <= phase_d;
            popped_q     <= popped_d;
            empty_a_q    <= empty_a_d;
            byte_mode_q  <= byte_mode_d;
            status_q     <= status_d;
            slot_q       <= slot_d;
            nwords_q     <= nwords_d;
            filled_q     <= filled_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ntr_cmd_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_ntr_cmd_sched
// Brief    : Directed self-checking bench for ntr_cmd_sched with a small FIFO model
// Revision : 1.0 - initial release
// ============================================================================
module tb_ntr_cmd_sched;

    localparam logic [31:0] c_CHIP_ID = 32'h807F01E0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    ntr_cmd_sched_if bus ();

    ntr_cmd_sched #(
        .MAX_WORDS (128),
        .CHIP_ID   (c_CHIP_ID)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // FIFO model: one-cycle read latency, write side filled by the stimulus
    logic [7:0] fifo_mem [0:255];
    logic [7:0] wp       = 8'd0;
    logic [7:0] rp       = 8'd0;
    logic [7:0] fifo_q   = 8'd0;
    logic       flush    = 1'b0;
    logic       prev_rd  = 1'b0;
    logic       b2b_seen = 1'b0;
    int         pop_cnt  = 0;

    assign bus.fifo_data  = fifo_q;
    assign bus.fifo_empty = (rp == wp);

    always @(posedge clk) begin
        prev_rd <= bus.fifo_rd_en;
        if (bus.fifo_rd_en && prev_rd) b2b_seen <= 1'b1;
        if (flush) begin
            rp <= wp;
        end else if (bus.fifo_rd_en) begin
            fifo_q  <= fifo_mem[rp];
            rp      <= rp + 8'd1;
            pop_cnt <= pop_cnt + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fifo_push(input logic [7:0] b);
        fifo_mem[wp] = b;
        wp = wp + 8'd1;
    endtask

    task automatic fifo_flush();
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
    endtask

    task automatic start_cmd(input logic [63:0] c);
        bus.command   = c;
        bus.cmd_ready = 1'b1;
    endtask

    task automatic end_cmd();
        bus.cmd_ready = 1'b0;
        tick(1);
    endtask

    task automatic pulse_req();
        bus.word_req = 1'b1;
        tick(1);
        bus.word_req = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (bus.word_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        tick(2);
        n_chk++; if (bus.data_word !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 00000000", bus.data_word); end
        n_chk++; if ({bus.word_valid, bus.fifo_rd_en, bus.led, bus.busy} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {bus.word_valid, bus.fifo_rd_en, bus.led, bus.busy}); end
        n_chk++; if (bus.status !== 2'b00) begin n_fail++; $display("FAIL reset_status: got %b want 00", bus.status); end
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_chip_id();
        start_cmd(64'h90);
        tick(1);
        n_chk++; if (bus.word_valid !== 1'b0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL chipid_decode: valid %b busy %b want 0 1", bus.word_valid, bus.busy); end
        tick(1);
        n_chk++; if (bus.word_valid !== 1'b1) begin n_fail++; $display("FAIL chipid_valid: got %b want 1", bus.word_valid); end
        n_chk++; if (bus.data_word !== c_CHIP_ID) begin n_fail++; $display("FAIL chipid_data: got %h want %h", bus.data_word, c_CHIP_ID); end
        pulse_req();
        n_chk++; if (bus.word_valid !== 1'b0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL chipid_done: valid %b busy %b want 0 1", bus.word_valid, bus.busy); end
        pulse_req();
        n_chk++; if (bus.data_word !== 32'h0) begin n_fail++; $display("FAIL done_req_data: got %h want 00000000", bus.data_word); end
        n_chk++; if (bus.status !== 2'b00) begin n_fail++; $display("FAIL done_req_status: got %b want 00", bus.status); end
        end_cmd();
        n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL chipid_idle: busy %b want 0", bus.busy); end
    endtask

    task automatic test_led();
        start_cmd(64'h0100_0000_0000_00FF);
        tick(2);
        n_chk++; if (bus.led !== 1'b1 || bus.data_word !== 32'd1) begin n_fail++; $display("FAIL led_on: led %b data %h want 1 00000001", bus.led, bus.data_word); end
        pulse_req();
        end_cmd();
        start_cmd(64'h0000_0000_0000_00FF);
        tick(2);
        n_chk++; if (bus.led !== 1'b0 || bus.data_word !== 32'd1) begin n_fail++; $display("FAIL led_off: led %b data %h want 0 00000001", bus.led, bus.data_word); end
        pulse_req();
        end_cmd();
    endtask

    task automatic test_bulk();
        bit ok;
        int p0;
        for (int i = 0; i < 8; i++) fifo_push(8'h11 + 8'(i));
        p0 = pop_cnt;
        start_cmd(64'h0223);
        wait_valid(30, ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL bulk_w0_timeout: word_valid never rose"); end
        n_chk++; if (bus.data_word !== 32'h14131211) begin n_fail++; $display("FAIL bulk_w0: got %h want 14131211", bus.data_word); end
        tick(20);
        pulse_req();
        n_chk++; if (bus.word_valid !== 1'b1 || bus.data_word !== 32'h18171615) begin n_fail++; $display("FAIL bulk_w1: valid %b data %h want 1 18171615", bus.word_valid, bus.data_word); end
        tick(20);
        pulse_req();
        n_chk++; if (bus.word_valid !== 1'b0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL bulk_done: valid %b busy %b want 0 1", bus.word_valid, bus.busy); end
        n_chk++; if (pop_cnt - p0 !== 8) begin n_fail++; $display("FAIL bulk_pops: got %0d want 8", pop_cnt - p0); end
        n_chk++; if (bus.status !== 2'b00) begin n_fail++; $display("FAIL bulk_status: got %b want 00", bus.status); end
        n_chk++; if (b2b_seen !== 1'b0) begin n_fail++; $display("FAIL bulk_b2b: rd_en back-to-back %b want 0", b2b_seen); end
        end_cmd();
    endtask

    task automatic test_underrun();
        bit ok;
        fifo_push(8'hAB);
        start_cmd(64'h0123);
        wait_valid(30, ok);
        n_chk++; if (!ok || bus.data_word !== 32'h000000AB) begin n_fail++; $display("FAIL underrun_word: ok %b data %h want 1 000000ab", ok, bus.data_word); end
        n_chk++; if (bus.status !== 2'b01) begin n_fail++; $display("FAIL underrun_status: got %b want 01", bus.status); end
        pulse_req();
        end_cmd();
        start_cmd(64'h24);
        tick(2);
        n_chk++; if (bus.data_word !== 32'h00000101) begin n_fail++; $display("FAIL status_read: got %h want 00000101", bus.data_word); end
        n_chk++; if (bus.status !== 2'b00) begin n_fail++; $display("FAIL status_clear: got %b want 00", bus.status); end
        pulse_req();
        end_cmd();
    endtask

    task automatic test_byte_empty();
        bit ok;
        int p0;
        p0 = pop_cnt;
        start_cmd(64'h22);
        wait_valid(20, ok);
        n_chk++; if (!ok || bus.data_word !== 32'h01000000) begin n_fail++; $display("FAIL byte_empty: ok %b data %h want 1 01000000", ok, bus.data_word); end
        n_chk++; if (pop_cnt !== p0) begin n_fail++; $display("FAIL byte_empty_pops: got %0d want 0", pop_cnt - p0); end
        pulse_req();
        end_cmd();
    endtask

    task automatic test_late_req();
        bit ok;
        for (int i = 1; i <= 4; i++) fifo_push(8'(i));
        start_cmd(64'h0123);
        tick(4);
        pulse_req();
        n_chk++; if (bus.status[1] !== 1'b1) begin n_fail++; $display("FAIL late_req: got %b want 1", bus.status[1]); end
        n_chk++; if (bus.data_word !== 32'h01000000) begin n_fail++; $display("FAIL late_data: got %h want 01000000", bus.data_word); end
        wait_valid(20, ok);
        n_chk++; if (!ok || bus.data_word !== 32'h04030201) begin n_fail++; $display("FAIL late_word: ok %b data %h want 1 04030201", ok, bus.data_word); end
        pulse_req();
        n_chk++; if (bus.status !== 2'b11 || bus.word_valid !== 1'b0) begin n_fail++; $display("FAIL late_end: status %b valid %b want 11 0", bus.status, bus.word_valid); end
        end_cmd();
    endtask

    task automatic test_clamp();
        bit ok;
        int got;
        got = 0;
        start_cmd(64'h8123);
        for (int k = 0; k < 128; k++) begin
            wait_valid(20, ok);
            if (ok) got++;
            pulse_req();
        end
        tick(20);
        n_chk++; if (got !== 128) begin n_fail++; $display("FAIL clamp_words: got %0d want 128", got); end
        n_chk++; if (bus.word_valid !== 1'b0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL clamp_done: valid %b busy %b want 0 1", bus.word_valid, bus.busy); end
        end_cmd();
        start_cmd(64'h0023);
        wait_valid(20, ok);
        pulse_req();
        tick(20);
        n_chk++; if (!ok || bus.word_valid !== 1'b0) begin n_fail++; $display("FAIL zero_count: ok %b valid %b want 1 0", ok, bus.word_valid); end
        end_cmd();
    endtask

    task automatic test_abort();
        bit ok;
        int p0;
        int p1;
        for (int i = 0; i < 64; i++) fifo_push(8'(i));
        p0 = pop_cnt;
        start_cmd(64'hFF23);
        wait_valid(30, ok);
        n_chk++; if (!ok || bus.data_word !== 32'h03020100) begin n_fail++; $display("FAIL abort_w0: ok %b data %h want 1 03020100", ok, bus.data_word); end
        tick(10);
        pulse_req();
        n_chk++; if (bus.data_word !== 32'h07060504) begin n_fail++; $display("FAIL abort_w1: got %h want 07060504", bus.data_word); end
        tick(10);
        pulse_req();
        n_chk++; if (bus.data_word !== 32'h0B0A0908) begin n_fail++; $display("FAIL abort_w2: got %h want 0b0a0908", bus.data_word); end
        bus.cmd_ready = 1'b0;
        tick(1);
        n_chk++; if (bus.busy !== 1'b0 || bus.word_valid !== 1'b0) begin n_fail++; $display("FAIL abort_idle: busy %b valid %b want 0 0", bus.busy, bus.word_valid); end
        p1 = pop_cnt;
        n_chk++; if (p1 - p0 < 12 || p1 - p0 > 36) begin n_fail++; $display("FAIL abort_pops: got %0d want 12..36", p1 - p0); end
        tick(10);
        n_chk++; if (pop_cnt !== p1) begin n_fail++; $display("FAIL abort_no_more_pops: got %0d want %0d", pop_cnt, p1); end
        fifo_flush();
    endtask

    task automatic test_reset_mid_fill();
        int p0;
        start_cmd(64'h0100_0000_0000_00FF);
        tick(2);
        pulse_req();
        end_cmd();
        for (int i = 0; i < 8; i++) fifo_push(8'h40 + 8'(i));
        start_cmd(64'h0223);
        tick(2);
        n_chk++; if (bus.fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL fill_rd_en: got %b want 1", bus.fifo_rd_en); end
        rst_n = 1'b0;
        #1;
        n_chk++; if ({bus.fifo_rd_en, bus.word_valid, bus.led, bus.busy} !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_flags: got %b want 0000", {bus.fifo_rd_en, bus.word_valid, bus.led, bus.busy}); end
        n_chk++; if (bus.data_word !== 32'h0 || bus.status !== 2'b00) begin n_fail++; $display("FAIL rst_mid_data: data %h status %b want 00000000 00", bus.data_word, bus.status); end
        bus.cmd_ready = 1'b0;
        tick(2);
        rst_n = 1'b1;
        p0 = pop_cnt;
        tick(10);
        n_chk++; if (pop_cnt !== p0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_after: pops %0d busy %b want %0d 0", pop_cnt, bus.busy, p0); end
        fifo_flush();
    endtask

    initial begin
        bus.command   = 64'h0;
        bus.cmd_ready = 1'b0;
        bus.word_req  = 1'b0;
        test_reset();
        test_chip_id();
        test_led();
        test_bulk();
        test_underrun();
        test_byte_empty();
        test_late_req();
        test_clamp();
        test_abort();
        test_reset_mid_fill();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
